// File: rtl/mem_stage_access_unit.sv
// MEM-stage data-memory access unit: load/store handshake, byte-lane steering, load extension.
// Latency: request cycle + >=1 ACCESS cycle (until DMEM_BUSYWAIT drops or TIMEOUT) + 1 DONE cycle.
// Backpressure: STALL holds the upstream pipeline from an accepted request until DONE; BUSYWAIT stretches ACCESS.
module mem_stage_access_unit #(
  parameter int TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MEM_READ,
  input  logic        MEM_WRITE,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] STORE_DATA,
  output logic        DMEM_READ,
  output logic        DMEM_WRITE,
  output logic [31:0] DMEM_ADDRESS,
  output logic [31:0] DMEM_WDATA,
  output logic [3:0]  DMEM_BYTE_EN,
  input  logic [31:0] DMEM_RDATA,
  input  logic        DMEM_BUSYWAIT,
  output logic [31:0] LOAD_DATA,
  output logic        STALL,
  output logic        MISALIGNED,
  output logic        BUS_ERROR
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  // Index of the last ACCESS cycle allowed before the access is abandoned.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [2:0]  funct3_q;
  logic        write_q;
  logic [31:0] load_q;
  logic        bus_err_q;

  logic        req;
  logic        misaligned;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic        accept;
  logic        timeout_hit;
  logic        stall_c;
  logic        misal_c;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  // Decode the presented request: lane enables, replicated store data, alignment.
  always_comb begin
    req        = MEM_READ | MEM_WRITE;
    be_nxt     = 4'b1111;
    wdata_nxt  = STORE_DATA;
    misaligned = 1'b0;
    case (FUNCT3[1:0])
      2'b00: begin
        be_nxt    = 4'b0001 << ADDRESS[1:0];
        wdata_nxt = {4{STORE_DATA[7:0]}};
      end
      2'b01: begin
        be_nxt     = 4'b0011 << {ADDRESS[1], 1'b0};
        wdata_nxt  = {2{STORE_DATA[15:0]}};
        misaligned = ADDRESS[0];
      end
      default: misaligned = |ADDRESS[1:0];
    endcase
  end

  // Steer the addressed lane of the read word and extend it per the captured size/sign.
  always_comb begin
    case (addr_q[1:0])
      2'b00:   byte_sel = DMEM_RDATA[7:0];
      2'b01:   byte_sel = DMEM_RDATA[15:8];
      2'b10:   byte_sel = DMEM_RDATA[23:16];
      default: byte_sel = DMEM_RDATA[31:24];
    endcase
    half_sel = addr_q[1] ? DMEM_RDATA[31:16] : DMEM_RDATA[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'd0, byte_sel};
      3'b101:  load_ext = {16'd0, half_sel};
      default: load_ext = DMEM_RDATA;
    endcase
  end

  // Next-state logic plus the combinational STALL / MISALIGNED flags.
  always_comb begin
    state_nxt   = state;
    stall_c     = 1'b0;
    misal_c     = 1'b0;
    accept      = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (misaligned) begin
            misal_c = 1'b1;
          end else begin
            stall_c   = 1'b1;
            accept    = 1'b1;
            state_nxt = ACCESS;
          end
        end
      end
      ACCESS: begin
        stall_c = 1'b1;
        if (!DMEM_BUSYWAIT) begin
          state_nxt = DONE;
        end else if (cnt == TIMEOUT_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = DONE;
        end
      end
      // The pipeline advances at this edge; whatever is still on the inputs is stale.
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (RESET) begin
      stall_c = 1'b0;
      misal_c = 1'b0;
      accept  = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // Cycles spent in ACCESS; cleared in every other state.
  always_ff @(posedge CLK) begin
    if (RESET || state != ACCESS) cnt <= 8'd0;
    else                          cnt <= cnt + 8'd1;
  end

  // Capture the request so the memory sees stable values for the whole access.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      be_q     <= 4'd0;
      funct3_q <= 3'd0;
      write_q  <= 1'b0;
    end else if (accept) begin
      addr_q   <= ADDRESS;
      wdata_q  <= wdata_nxt;
      be_q     <= be_nxt;
      funct3_q <= FUNCT3;
      write_q  <= MEM_WRITE;
    end
  end

  // Load result and bus-error pulse, both resolved at the end of ACCESS.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      load_q    <= 32'd0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= 1'b0;
      if (state == ACCESS) begin
        if (!DMEM_BUSYWAIT) begin
          if (!write_q) load_q <= load_ext;
        end else if (timeout_hit) begin
          load_q    <= 32'd0;
          bus_err_q <= 1'b1;
        end
      end
    end
  end

  assign DMEM_READ    = (state == ACCESS) && !write_q;
  assign DMEM_WRITE   = (state == ACCESS) && write_q;
  assign DMEM_ADDRESS = {addr_q[31:2], 2'b00};
  assign DMEM_WDATA   = wdata_q;
  assign DMEM_BYTE_EN = be_q;
  assign LOAD_DATA    = load_q;
  assign BUS_ERROR    = bus_err_q;
  assign STALL        = stall_c;
  assign MISALIGNED   = misal_c;

endmodule

// File: doc/mem_stage_access_unit.md
Name: mem_stage_access_unit

Overview:
MEM-stage consumer of the EX/MEM pipeline register outputs in the RV32IM pipeline.
- Turns the registered MEM_READ/MEM_WRITE/FUNCT3/ALU-result/store-data fields into a multi-cycle handshake with data memory.
- Generates byte enables and store-data lane replication.
- Extracts and sign/zero-extends load data.
- Raises STALL to freeze the upstream pipeline while an access is outstanding.

Parameters:
TIMEOUT, 15, max cycles in ACCESS waiting for DMEM_BUSYWAIT to drop before aborting with BUS_ERROR (1..255).

Ports:
CLK  input  1  clock; all state updates on posedge
RESET  input  1  synchronous, active-high reset
MEM_READ  input  1  load request from EX/MEM register
MEM_WRITE  input  1  store request from EX/MEM register
FUNCT3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
ADDRESS  input  32  effective address (ALU result)
STORE_DATA  input  32  rs2 value for stores
DMEM_READ  output  1  memory read strobe
DMEM_WRITE  output  1  memory write strobe
DMEM_ADDRESS  output  32  word-aligned address (ADDRESS with [1:0] forced to 00)
DMEM_WDATA  output  32  lane-replicated store data
DMEM_BYTE_EN  output  4  byte-lane enables
DMEM_RDATA  input  32  memory read word
DMEM_BUSYWAIT  input  1  high while memory has not completed
LOAD_DATA  output  32  extended load result to MEM/WB register
STALL  output  1  high: upstream pipeline must hold
MISALIGNED  output  1  one-cycle flag: misaligned request, dropped
BUS_ERROR  output  1  one-cycle flag: access aborted on timeout

Behaviour:
- Reset: at posedge with RESET=1, state <= IDLE and the cycle counter clears. Outputs after reset:
  - DMEM_READ, DMEM_WRITE, DMEM_BYTE_EN, DMEM_ADDRESS, DMEM_WDATA = 0.
  - LOAD_DATA = 0; BUS_ERROR = 0.
  - STALL and MISALIGNED are 0 while RESET is high.
- Reset mid-access aborts the access: the strobes are low from the following cycle, and no LOAD_DATA update occurs.
- States: IDLE, ACCESS, DONE.
- IDLE: a request is MEM_WRITE=1 or MEM_READ=1. If both are high, the request is a write and the read is ignored.
  - Alignment: a halfword request with ADDRESS[0]=1 is misaligned. A word request (FUNCT3[1:0]=10, and also 011/110/111, which are treated as word) with ADDRESS[1:0]!=00 is misaligned.
  - Misaligned request: MISALIGNED=1 combinationally for that cycle, STALL=0, no memory access, stay IDLE.
  - Aligned request: STALL=1 combinationally. Capture address, byte enables, write data, FUNCT3 and direction into registers. Go to ACCESS.
- ACCESS:
  - Registered strobes: DMEM_READ or DMEM_WRITE is high, DMEM_ADDRESS/WDATA/BYTE_EN are driven from the captured registers. STALL=1.
  - Counter increments every ACCESS cycle.
  - Posedge with DMEM_BUSYWAIT=0: for a read, capture the extended DMEM_RDATA into LOAD_DATA. Then go to DONE.
  - Counter reaches TIMEOUT with BUSYWAIT still high: go to DONE, LOAD_DATA <= 0, BUS_ERROR=1 for the DONE cycle.
  - Minimum latency is request cycle + 1 ACCESS cycle + DONE.
- DONE:
  - Strobes low, STALL=0 (the pipeline advances at this edge), counter clears.
  - The request still presented on the inputs this cycle is not re-accepted. Next state is IDLE.
- Byte enables:
  - byte: 0001 << ADDRESS[1:0]
  - half: 0011 << {ADDRESS[1],1'b0}
  - word: 1111
- Store data replication: byte {4{STORE_DATA[7:0]}}, half {2{STORE_DATA[15:0]}}, word unchanged.
- Load extraction: select the lane by captured ADDRESS[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW and the other encodings return the full word.
- LOAD_DATA holds its value until the next completed read, timeout or reset. Writes do not change it.
- Outputs never go X after reset.

Test Plan:
1. LW addr 0x100, BUSYWAIT low on first ACCESS cycle, RDATA 0xDEADBEEF:
   - DMEM_READ high exactly 1 cycle, DMEM_ADDRESS 0x100, BYTE_EN 1111.
   - STALL high 2 cycles; LOAD_DATA 0xDEADBEEF in DONE.
2. LB/LBU/LH/LHU at addr 0x203/0x202, RDATA 0x80FF7F01:
   - LB at 0x203 gives 0xFFFFFF80; LBU at 0x203 gives 0x00000080.
   - LH at 0x202 gives 0xFFFF80FF; LHU at 0x202 gives 0x000080FF.
3. SB addr 0x101, STORE_DATA 0x12345678:
   - BYTE_EN 0010, WDATA 0x78787878, DMEM_WRITE high.
   - LOAD_DATA unchanged from previous value.
4. BUSYWAIT held high 3 cycles then low:
   - STALL high 5 cycles total, strobe held 4 cycles, single completion, no re-issue in DONE.
5. BUSYWAIT stuck high, TIMEOUT=15:
   - After 15 ACCESS cycles: BUS_ERROR pulses 1 cycle, LOAD_DATA 0, return to IDLE.
6. Edge cases:
   - LW at 0x102: MISALIGNED 1 cycle, no strobe, STALL 0.
   - MEM_READ=MEM_WRITE=1: write issued.
   - RESET asserted during ACCESS: strobes 0 next cycle, STALL 0, state IDLE.
